queue_output_arbiter: RTL

//  N-to-1 AXI-Stream arbiter that drains the per-port signalled queues of the

---
 rtl/queue_output_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/queue_output_arbiter.sv
// queue_output_arbiter: round-robin N-to-1 AXI-Stream arbiter with bounded bursts and a registered output.
// Define ARB_OCCUPANCY_PRIO_EN to make half-full queues win arbitration ahead of the rest.
package queue_output_arbiter_pkg;
    localparam int AXIS_DATA_WIDTH = 32;
    localparam int ID_WIDTH        = 4;
    localparam int DEST_WIDTH      = 4;
    localparam int USER_WIDTH      = 4;
    typedef struct packed {
        logic                         tvalid;
        logic [AXIS_DATA_WIDTH-1:0]   tdata;
        logic [AXIS_DATA_WIDTH/8-1:0] tkeep;
        logic                         tlast;
        logic [ID_WIDTH-1:0]          tid;
        logic [DEST_WIDTH-1:0]        tdest;
        logic [USER_WIDTH-1:0]        tuser;
    } axis_mosi_t;
    typedef struct packed {
        logic tready;
    } axis_miso_t;
endpackage

module queue_output_arbiter
    import queue_output_arbiter_pkg::*;
#(
    parameter int N_INPUTS  = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  axis_mosi_t          in_mosi_i [N_INPUTS],
    output axis_miso_t          in_miso_o [N_INPUTS],
    input  logic [N_INPUTS-1:0] q_empty_i,
    input  logic [N_INPUTS-1:0] q_half_full_i,
    output axis_mosi_t          out_mosi_o,
    input  axis_miso_t          out_miso_i,
    output logic [N_INPUTS-1:0] grant_o,
    output logic                busy_o
);
    localparam int PW = $clog2(N_INPUTS);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, GRANTED} state_t;

    state_t              r_state, w_next;
    logic [PW-1:0]       r_rr_ptr, w_winner;
    logic [CW-1:0]       r_beat_cnt;
    logic [N_INPUTS-1:0] r_grant, w_req, w_cand;
    axis_mosi_t          r_out;
    logic                w_load_en, w_src_valid, w_beat, w_release;

    always_comb begin
        for (int i = 0; i < N_INPUTS; i++)
            w_req[i] = in_mosi_i[i].tvalid & ~q_empty_i[i];
    end

`ifdef ARB_OCCUPANCY_PRIO_EN
    assign w_cand = |(w_req & q_half_full_i) ? (w_req & q_half_full_i) : w_req;
`else
    logic w_unused_half_full;
    assign w_unused_half_full = ^q_half_full_i;
    assign w_cand = w_req;
`endif

    // Scan from farthest to nearest so the first requester after rr_ptr wins.
    always_comb begin
        w_winner = r_rr_ptr;
        for (int k = N_INPUTS; k >= 1; k--)
            if (w_cand[PW'((int'(r_rr_ptr) + k) % N_INPUTS)])
                w_winner = PW'((int'(r_rr_ptr) + k) % N_INPUTS);
    end

    // While granted, rr_ptr holds the granted port index.
    always_comb begin
        w_load_en   = ~r_out.tvalid | out_miso_i.tready;
        w_src_valid = in_mosi_i[r_rr_ptr].tvalid;
        w_beat      = (r_state == GRANTED) & w_src_valid & w_load_en;
        w_release   = (r_state == GRANTED) &
                      ((w_beat & (r_beat_cnt == CW'(MAX_BURST - 1))) | (w_load_en & ~w_src_valid));
        w_next      = r_state;
        if (r_state == IDLE && |w_req)
            w_next = GRANTED;
        else if (w_release)
            w_next = IDLE;
        for (int i = 0; i < N_INPUTS; i++)
            in_miso_o[i].tready = (r_state == GRANTED) & r_grant[i] & w_load_en;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rr_ptr   <= PW'(N_INPUTS - 1);
            r_beat_cnt <= '0;
            r_grant    <= '0;
            r_out      <= '0;
        end else begin
            if (r_state == IDLE && |w_req) begin
                r_grant    <= N_INPUTS'(1) << w_winner;
                r_rr_ptr   <= w_winner;
                r_beat_cnt <= '0;
            end else if (w_release) begin
                r_grant <= '0;
            end
            if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
                r_out      <= in_mosi_i[r_rr_ptr];
            end else if (r_out.tvalid & out_miso_i.tready) begin
                r_out.tvalid <= 1'b0;
            end
        end
    end

    assign out_mosi_o = r_out;
    assign grant_o    = r_grant;
    assign busy_o     = (r_state == GRANTED);
endmodule
